// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants for the nibble-serial adder: FSM encoding and adder-cell width.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_add_cell.sv
// nibble_add_cell: combinational 4-bit ripple adder with carry-in, shared by every nibble step.
module nibble_add_cell
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] sum,
    output logic                c_out
);

    logic carry;

    always_comb begin
        sum   = '0;
        carry = c_in;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c_out = carry;
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder sequencer: one shared 4-bit cell, LSB nibble first, carry held between steps.
// Build macro NIBBLE_SERIAL_SUB_EN adds a 'sub' port selecting a - b (c_out=1 means no borrow).
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         start,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic                         sub,
`endif
    input  logic [NIBBLE_W*NIBBLES-1:0]  a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  b,
    input  logic                         c_in,
    output logic                         busy,
    output logic                         done,
    output logic [NIBBLE_W*NIBBLES-1:0]  sum,
    output logic                         c_out
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t              state, state_nx;
    logic [W-1:0]        a_sh, b_sh, part, part_nx;
    logic [W+NIBBLE_W-1:0] part_ext;
    logic [IDX_W-1:0]    idx;
    logic                cy, co;
    logic [NIBBLE_W-1:0] b_nib, s;
    logic                accept, last;
    logic                sub_q;

    // Start is honoured only from IDLE or DONE; DONE acceptance gives back-to-back operation.
    always_comb begin
        accept   = start && (state == ST_IDLE || state == ST_DONE);
        last     = (state == ST_RUN) && (idx == LAST_IDX);
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: if (accept) state_nx = ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (last) state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = accept ? ST_RUN : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) state <= ST_IDLE;
        else     state <= state_nx;
    end

    assign b_nib    = b_sh[NIBBLE_W-1:0] ^ {NIBBLE_W{sub_q}};
    assign part_ext = {s, part};
    assign part_nx  = part_ext[W+NIBBLE_W-1:NIBBLE_W];

    nibble_add_cell u_cell (
        .a     (a_sh[NIBBLE_W-1:0]),
        .b     (b_nib),
        .c_in  (cy),
        .sum   (s),
        .c_out (co)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            a_sh  <= '0;
            b_sh  <= '0;
            part  <= '0;
            idx   <= '0;
            cy    <= 1'b0;
            sub_q <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            part <= '0;
            idx  <= '0;
`ifdef NIBBLE_SERIAL_SUB_EN
            sub_q <= sub;
            cy    <= sub ? 1'b1 : c_in;
`else
            sub_q <= 1'b0;
            cy    <= c_in;
`endif
        end else if (state == ST_RUN) begin
            a_sh <= a_sh >> NIBBLE_W;
            b_sh <= b_sh >> NIBBLE_W;
            part <= part_nx;
            cy   <= co;
            idx  <= idx + IDX_W'(1);
            // Only the completed result is published; partial sums stay internal.
            if (last) begin
                sum   <= part_nx;
                c_out <= co;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl: directed cases plus randomized operations
// against an arithmetic reference model. Covers subtraction when NIBBLE_SERIAL_SUB_EN is defined.
module tb_nibble_serial_adder_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         clr, start, c_in, sub;
    logic [W-1:0] a, b;
    logic         busy, done, c_out;
    logic [W-1:0] sum;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_sum, pend_sum;
    logic         exp_cout, pend_cout;

    nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
`ifdef NIBBLE_SERIAL_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_done", 64'(done), 64'(0));
        check("idle_sum", 64'(sum), 64'(exp_sum));
        check("idle_cout", 64'(c_out), 64'(exp_cout));
    endtask

    // Called at a negedge; the following posedge accepts the operation.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic ci, input logic su);
        logic [W:0] r;
        logic       su_eff;
`ifdef NIBBLE_SERIAL_SUB_EN
        su_eff = su;
`else
        su_eff = 1'b0;
`endif
        a = av; b = bv; c_in = ci; sub = su; start = 1'b1;
        if (su_eff) r = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
        else        r = {1'b0, av} + {1'b0, bv} + (W+1)'(ci);
        pend_sum  = r[W-1:0];
        pend_cout = r[W];
        @(posedge clk);
    endtask

    // Follows the RUN phase with junk on the inputs, then checks the DONE cycle.
    task automatic track_op();
        for (int i = 0; i < NIBBLES; i++) begin
            @(negedge clk);
            check("run_busy", 64'(busy), 64'(1));
            check("run_done", 64'(done), 64'(0));
            check("run_sum_held", 64'(sum), 64'(exp_sum));
            check("run_cout_held", 64'(c_out), 64'(exp_cout));
            start = 1'($urandom);
            a     = W'($urandom);
            b     = W'($urandom);
            c_in  = 1'($urandom);
            sub   = 1'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        exp_sum  = pend_sum;
        exp_cout = pend_cout;
        check("done_pulse", 64'(done), 64'(1));
        check("done_busy", 64'(busy), 64'(0));
        check("done_sum", 64'(sum), 64'(exp_sum));
        check("done_cout", 64'(c_out), 64'(exp_cout));
        start = 1'b0;
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        exp_sum = '0; exp_cout = 1'b0; pend_sum = '0; pend_cout = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_cout", 64'(c_out), 64'(0));
        clr = 1'b0;

        idle_check(); start_op(16'h1234, 16'h4321, 1'b0, 1'b0); track_op();
        check("dir_5555", 64'(sum), 64'h5555);
        idle_check(); start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0); track_op();
        check("dir_ripple_cout", 64'(c_out), 64'(1));
        idle_check(); start_op(16'h0000, 16'h0000, 1'b1, 1'b0); track_op();
        check("dir_cin_sum", 64'(sum), 64'h0001);

        // Start held in DONE launches the next operation immediately.
        start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0); track_op();
        check("b2b_sum", 64'(sum), 64'h1010);

        // Abort with clr on the second RUN edge.
        idle_check(); start_op(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        exp_sum = '0; exp_cout = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_sum", 64'(sum), 64'(0));
        check("abort_cout", 64'(c_out), 64'(0));
        repeat (NIBBLES + 1) idle_check();
        start_op(16'h1111, 16'h2222, 1'b0, 1'b0); track_op();

`ifdef NIBBLE_SERIAL_SUB_EN
        idle_check(); start_op(16'h0005, 16'h0007, 1'b0, 1'b1); track_op();
        check("sub_neg_sum", 64'(sum), 64'hFFFE);
        check("sub_neg_cout", 64'(c_out), 64'(0));
        idle_check(); start_op(16'h0007, 16'h0005, 1'b0, 1'b1); track_op();
        check("sub_pos_sum", 64'(sum), 64'h0002);
        check("sub_pos_cout", 64'(c_out), 64'(1));
`endif

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(2, 0) != 0) idle_check();
            start_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            track_op();
        end
        idle_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
